// File: rtl/spim_avmm_arb.sv
// Two-requester round-robin arbiter sharing one SPI master AVMM port (IDLE/CMD/RDWAIT).
// Define SPIM_AVMM_ARB_TIMEOUT_EN to enable the CMD/RDWAIT watchdog and arb_timeout pulse.
module spim_avmm_arb #(
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic        m_avmm_clk,
    input  logic        m_avmm_rst,

    input  logic [16:0] r0_avmm_addr,
    input  logic [3:0]  r0_avmm_byte_en,
    input  logic        r0_avmm_write,
    input  logic        r0_avmm_read,
    input  logic [31:0] r0_avmm_wdata,
    output logic [31:0] r0_avmm_rdata,
    output logic        r0_avmm_rdatavld,
    output logic        r0_avmm_waitreq,

    input  logic [16:0] r1_avmm_addr,
    input  logic [3:0]  r1_avmm_byte_en,
    input  logic        r1_avmm_write,
    input  logic        r1_avmm_read,
    input  logic [31:0] r1_avmm_wdata,
    output logic [31:0] r1_avmm_rdata,
    output logic        r1_avmm_rdatavld,
    output logic        r1_avmm_waitreq,

    output logic [16:0] m_avmm_addr,
    output logic [3:0]  m_avmm_byte_en,
    output logic        m_avmm_write,
    output logic        m_avmm_read,
    output logic [31:0] m_avmm_wdata,
    input  logic [31:0] m_avmm_rdata,
    input  logic        m_avmm_rdatavld,
    input  logic        m_avmm_waitreq,

    output logic        arb_timeout
);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StCmd    = 2'd1;
    localparam logic [1:0] StRdwait = 2'd2;

    logic [1:0]  state_q, state_d;
    logic        grant_q, grant_d;   // 0: r0, 1: r1
    logic        last_q, last_d;     // requester that completed most recently
    logic        req0, req1;
    logic        g_write, g_read;
    logic [16:0] g_addr;
    logic [3:0]  g_byte_en;
    logic [31:0] g_wdata;
    logic        timeout;
    logic        in_cmd;
    logic        rd_vld;
    logic [31:0] rd_data;

    always_comb begin
        req0      = r0_avmm_read | r0_avmm_write;
        req1      = r1_avmm_read | r1_avmm_write;
        g_write   = grant_q ? r1_avmm_write   : r0_avmm_write;
        g_read    = grant_q ? r1_avmm_read    : r0_avmm_read;
        g_addr    = grant_q ? r1_avmm_addr    : r0_avmm_addr;
        g_byte_en = grant_q ? r1_avmm_byte_en : r0_avmm_byte_en;
        g_wdata   = grant_q ? r1_avmm_wdata   : r0_avmm_wdata;
    end

`ifdef SPIM_AVMM_ARB_TIMEOUT_EN
    localparam logic [9:0] TimeoutLimit = 10'(TIMEOUT_CYCLES);

    logic [9:0] cnt_q;

    // Restarts on every state change, so CMD and RDWAIT are each bounded separately.
    always_ff @(posedge m_avmm_clk) begin
        if (m_avmm_rst) begin
            cnt_q <= 10'd0;
        end else if (state_d != state_q) begin
            cnt_q <= 10'd0;
        end else if (state_q != StIdle) begin
            cnt_q <= cnt_q + 10'd1;
        end
    end

    always_comb begin
        timeout = !m_avmm_rst && (state_q != StIdle) && (cnt_q == TimeoutLimit);
    end
`else
    always_comb begin
        timeout = 1'b0;
    end
`endif

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        case (state_q)
            StIdle: begin
                if (req0 || req1) begin
                    grant_d = (req0 && req1) ? ~last_q : req1;
                    state_d = StCmd;
                end
            end
            StCmd: begin
                if (timeout) begin
                    state_d = StIdle;
                    last_d  = grant_q;
                end else if (!g_read && !g_write) begin
                    state_d = StIdle;
                end else if (!m_avmm_waitreq) begin
                    if (g_write) begin
                        state_d = StIdle;
                        last_d  = grant_q;
                    end else begin
                        state_d = StRdwait;
                    end
                end
            end
            StRdwait: begin
                if (timeout || m_avmm_rdatavld) begin
                    state_d = StIdle;
                    last_d  = grant_q;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge m_avmm_clk) begin
        if (m_avmm_rst) begin
            state_q <= StIdle;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    // Outputs are gated by reset directly so they are quiet even before the reset edge.
    always_comb begin
        in_cmd         = !m_avmm_rst && (state_q == StCmd);
        m_avmm_write   = in_cmd && g_write;
        m_avmm_read    = in_cmd && g_read && !g_write;
        m_avmm_addr    = in_cmd ? g_addr    : 17'd0;
        m_avmm_byte_en = in_cmd ? g_byte_en : 4'd0;
        m_avmm_wdata   = in_cmd ? g_wdata   : 32'd0;

        r0_avmm_waitreq = (in_cmd && !grant_q) ? m_avmm_waitreq : 1'b1;
        r1_avmm_waitreq = (in_cmd && grant_q)  ? m_avmm_waitreq : 1'b1;

        rd_vld  = !m_avmm_rst && (state_q == StRdwait) && (m_avmm_rdatavld || timeout);
        rd_data = timeout ? 32'hDEAD_BEEF : m_avmm_rdata;

        r0_avmm_rdatavld = rd_vld && !grant_q;
        r1_avmm_rdatavld = rd_vld && grant_q;
        r0_avmm_rdata    = r0_avmm_rdatavld ? rd_data : 32'd0;
        r1_avmm_rdata    = r1_avmm_rdatavld ? rd_data : 32'd0;

        arb_timeout = timeout;
    end

endmodule

// File: tb/tb_spim_avmm_arb.sv
// Scoreboard bench for spim_avmm_arb; the timeout scenario runs when SPIM_AVMM_ARB_TIMEOUT_EN is set.
module tb_spim_avmm_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic [16:0] r0_addr, r1_addr;
    logic [3:0]  r0_be, r1_be;
    logic        r0_write, r0_read, r1_write, r1_read;
    logic [31:0] r0_wdata, r1_wdata;
    logic [31:0] r0_rdata, r1_rdata;
    logic        r0_rdatavld, r1_rdatavld, r0_waitreq, r1_waitreq;
    logic [16:0] m_addr;
    logic [3:0]  m_be;
    logic        m_write, m_read;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        m_rdatavld, m_waitreq;
    logic        arb_timeout;

    typedef struct {
        logic        req;
        logic [16:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    spim_avmm_arb #(.TIMEOUT_CYCLES(8)) dut (
        .m_avmm_clk       (clk),
        .m_avmm_rst       (rst),
        .r0_avmm_addr     (r0_addr),
        .r0_avmm_byte_en  (r0_be),
        .r0_avmm_write    (r0_write),
        .r0_avmm_read     (r0_read),
        .r0_avmm_wdata    (r0_wdata),
        .r0_avmm_rdata    (r0_rdata),
        .r0_avmm_rdatavld (r0_rdatavld),
        .r0_avmm_waitreq  (r0_waitreq),
        .r1_avmm_addr     (r1_addr),
        .r1_avmm_byte_en  (r1_be),
        .r1_avmm_write    (r1_write),
        .r1_avmm_read     (r1_read),
        .r1_avmm_wdata    (r1_wdata),
        .r1_avmm_rdata    (r1_rdata),
        .r1_avmm_rdatavld (r1_rdatavld),
        .r1_avmm_waitreq  (r1_waitreq),
        .m_avmm_addr      (m_addr),
        .m_avmm_byte_en   (m_be),
        .m_avmm_write     (m_write),
        .m_avmm_read      (m_read),
        .m_avmm_wdata     (m_wdata),
        .m_avmm_rdata     (m_rdata),
        .m_avmm_rdatavld  (m_rdatavld),
        .m_avmm_waitreq   (m_waitreq),
        .arb_timeout      (arb_timeout)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        r0_addr = '0; r1_addr = '0; r0_be = '0; r1_be = '0;
        r0_write = 0; r0_read = 0; r1_write = 0; r1_read = 0;
        r0_wdata = '0; r1_wdata = '0;
        m_rdata = '0; m_rdatavld = 0; m_waitreq = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1;
        r0_write = 1; r0_addr = 17'h1; m_rdatavld = 1;
        tick();
        tick();
        @(negedge clk);
        checks++;
        if ({m_write, m_read, m_addr, m_be, m_wdata} !== 55'd0) begin
            errors++;
            $display("FAIL reset_m_outputs: got %h want 0", {m_write, m_read, m_addr, m_be, m_wdata});
        end
        checks++;
        if ({r0_waitreq, r1_waitreq} !== 2'b11) begin
            errors++;
            $display("FAIL reset_waitreq: got %b want 11", {r0_waitreq, r1_waitreq});
        end
        checks++;
        if ({r0_rdatavld, r1_rdatavld, arb_timeout} !== 3'b000) begin
            errors++;
            $display("FAIL reset_vld_timeout: got %b want 000", {r0_rdatavld, r1_rdatavld, arb_timeout});
        end
        @(posedge clk);
        #1;
        clear_inputs();
        rst = 0;
    endtask

    task automatic test_single_write();
        exp_t e;
        sb.push_back('{req: 1'b0, addr: 17'h0_0010, data: 32'h1234_5678});
        r0_addr = 17'h0_0010; r0_wdata = 32'h1234_5678; r0_be = 4'hF; r0_write = 1;
        m_waitreq = 0;
        for (int cyc = 1; cyc <= 4; cyc++) begin
            @(negedge clk);
            checks++;
            if (r1_waitreq !== 1'b1) begin
                errors++;
                $display("FAIL wr_r1_waitreq cyc%0d: got %b want 1", cyc, r1_waitreq);
            end
            checks++;
            if (m_write !== (cyc == 2)) begin
                errors++;
                $display("FAIL wr_m_write cyc%0d: got %b want %b", cyc, m_write, cyc == 2);
            end
            if (m_write === 1'b1 && m_waitreq === 1'b0 && sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if ({m_addr, m_wdata, m_be, r0_waitreq} !== {e.addr, e.data, 4'hF, 1'b0}) begin
                    errors++;
                    $display("FAIL wr_cmd: got %h/%h/%h/%b want %h/%h/f/0",
                             m_addr, m_wdata, m_be, r0_waitreq, e.addr, e.data);
                end
            end
            tick();
            if (cyc == 2) r0_write = 0;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL wr_sb_empty: got %0d entries want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_round_robin();
        exp_t e;
        int   n = 0;
        int   last_cyc = 0;
        rst = 1;
        tick();
        rst = 0;
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) sb.push_back('{req: 1'b0, addr: 17'h100, data: 32'hA0A0_0000});
            else            sb.push_back('{req: 1'b1, addr: 17'h200, data: 32'hB1B1_0000});
        end
        r0_addr = 17'h100; r0_wdata = 32'hA0A0_0000; r0_write = 1;
        r1_addr = 17'h200; r1_wdata = 32'hB1B1_0000; r1_write = 1;
        m_waitreq = 0;
        for (int cyc = 0; cyc < 20 && n < 4; cyc++) begin
            @(negedge clk);
            if (m_write === 1'b1 && m_waitreq === 1'b0) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL rr_extra: got write to %h want none", m_addr);
                end else begin
                    e = sb.pop_front();
                    if ({m_addr, m_wdata} !== {e.addr, e.data}) begin
                        errors++;
                        $display("FAIL rr_order%0d: got %h/%h want %h/%h", n, m_addr, m_wdata,
                                 e.addr, e.data);
                    end
                    checks++;
                    if ({r0_waitreq, r1_waitreq} !== (e.req ? 2'b10 : 2'b01)) begin
                        errors++;
                        $display("FAIL rr_waitreq%0d: got %b want %b", n, {r0_waitreq, r1_waitreq},
                                 e.req ? 2'b10 : 2'b01);
                    end
                end
                if (n > 0) begin
                    checks++;
                    if (cyc - last_cyc != 2) begin
                        errors++;
                        $display("FAIL rr_spacing%0d: got %0d want 2", n, cyc - last_cyc);
                    end
                end
                last_cyc = cyc;
                n++;
            end
            tick();
            if (n == 4) begin
                r0_write = 0;
                r1_write = 0;
            end
        end
        r0_write = 0; r1_write = 0;
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL rr_count: got %0d want 4", n);
            sb.delete();
        end
    endtask

    task automatic test_read();
        exp_t e;
        int   vld_cnt = 0;
        sb.push_back('{req: 1'b1, addr: 17'h55, data: 32'hA5A5_0001});
        r1_addr = 17'h55; r1_be = 4'hF; r1_read = 1;
        m_waitreq = 1;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk);
            checks++;
            if ({r0_waitreq, r0_rdatavld, r0_rdata} !== {1'b1, 1'b0, 32'd0}) begin
                errors++;
                $display("FAIL rd_r0_touched cyc%0d: got %b/%b/%h want 1/0/0", cyc, r0_waitreq,
                         r0_rdatavld, r0_rdata);
            end
            checks++;
            if ({m_read, r1_waitreq, r1_rdatavld} !==
                {cyc >= 1 && cyc <= 4, cyc != 4, cyc == 6}) begin
                errors++;
                $display("FAIL rd_seq cyc%0d: got %b want %b", cyc, {m_read, r1_waitreq, r1_rdatavld},
                         {cyc >= 1 && cyc <= 4, cyc != 4, cyc == 6});
            end
            if (m_read === 1'b1 && sb.size() > 0) begin
                checks++;
                if (m_addr !== sb[0].addr) begin
                    errors++;
                    $display("FAIL rd_addr: got %h want %h", m_addr, sb[0].addr);
                end
            end
            if (r1_rdatavld === 1'b1 && sb.size() > 0) begin
                e = sb.pop_front();
                vld_cnt++;
                checks++;
                if (r1_rdata !== e.data) begin
                    errors++;
                    $display("FAIL rd_data: got %h want %h", r1_rdata, e.data);
                end
            end
            tick();
            case (cyc + 1)
                4: m_waitreq = 0;
                5: begin r1_read = 0; m_waitreq = 1; end
                6: begin m_rdatavld = 1; m_rdata = 32'hA5A5_0001; end
                7: m_rdatavld = 0;
                8: begin m_rdatavld = 1; m_rdata = 32'h7777_7777; end
                9: m_rdatavld = 0;
                default: ;
            endcase
        end
        m_waitreq = 0;
        checks++;
        if (vld_cnt != 1 || sb.size() != 0) begin
            errors++;
            $display("FAIL rd_count: got %0d pulses/%0d left want 1/0", vld_cnt, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_rw_both();
        exp_t e;
        sb.push_back('{req: 1'b0, addr: 17'h77, data: 32'h7777_0000});
        r0_addr = 17'h77; r0_wdata = 32'h7777_0000; r0_write = 1; r0_read = 1;
        m_waitreq = 0;
        tick();
        @(negedge clk);
        checks++;
        if ({m_write, m_read} !== 2'b10) begin
            errors++;
            $display("FAIL rw_cmd: got w%b r%b want w1 r0", m_write, m_read);
        end
        if (m_write === 1'b1) begin
            e = sb.pop_front();
            checks++;
            if ({m_addr, m_wdata} !== {e.addr, e.data}) begin
                errors++;
                $display("FAIL rw_data: got %h/%h want %h/%h", m_addr, m_wdata, e.addr, e.data);
            end
        end
        tick();
        r0_write = 0; r0_read = 0;
        @(negedge clk);
        checks++;
        if ({m_write, m_read, r0_waitreq} !== 3'b001) begin
            errors++;
            $display("FAIL rw_after: got %b want 001", {m_write, m_read, r0_waitreq});
        end
        sb.delete();
        tick();
    endtask

    task automatic test_reset_rdwait();
        exp_t e;
        r0_addr = 17'h40; r0_read = 1; m_waitreq = 0;
        tick();
        tick();
        r0_read = 0; rst = 1; m_rdatavld = 1; m_rdata = 32'h0BAD_0BAD;
        @(negedge clk);
        checks++;
        if ({r0_waitreq, r0_rdatavld, r1_rdatavld, m_read} !== 4'b1000) begin
            errors++;
            $display("FAIL rst_rdwait: got %b want 1000", {r0_waitreq, r0_rdatavld, r1_rdatavld, m_read});
        end
        tick();
        rst = 0;
        @(negedge clk);
        checks++;
        if ({r0_rdatavld, r1_rdatavld} !== 2'b00) begin
            errors++;
            $display("FAIL rst_stray_vld: got %b want 00", {r0_rdatavld, r1_rdatavld});
        end
        tick();
        m_rdatavld = 0;
        sb.push_back('{req: 1'b1, addr: 17'h33, data: 32'h3333_3333});
        r1_addr = 17'h33; r1_wdata = 32'h3333_3333; r1_write = 1;
        @(negedge clk);
        checks++;
        if (m_write !== 1'b0) begin
            errors++;
            $display("FAIL rst_idle_cycle: got %b want 0", m_write);
        end
        tick();
        @(negedge clk);
        checks++;
        if (m_write !== 1'b1 || r1_waitreq !== 1'b0) begin
            errors++;
            $display("FAIL rst_next_grant: got w%b wr%b want w1 wr0", m_write, r1_waitreq);
            sb.delete();
        end else begin
            e = sb.pop_front();
            checks++;
            if ({m_addr, m_wdata} !== {e.addr, e.data}) begin
                errors++;
                $display("FAIL rst_next_data: got %h/%h want %h/%h", m_addr, m_wdata, e.addr, e.data);
            end
        end
        tick();
        r1_write = 0;
        tick();
    endtask

`ifdef SPIM_AVMM_ARB_TIMEOUT_EN
    task automatic test_timeout();
        exp_t e;
        int   pulses = 0;
        int   got = 0;
        int   found = 0;
        sb.push_back('{req: 1'b0, addr: 17'h60, data: 32'hDEAD_BEEF});
        r0_addr = 17'h60; r0_read = 1; m_waitreq = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (arb_timeout === 1'b1) pulses++;
            if (r0_rdatavld === 1'b1 && sb.size() > 0) begin
                e = sb.pop_front();
                got++;
                checks++;
                if ({r0_rdata, arb_timeout, r1_rdatavld} !== {e.data, 1'b1, 1'b0}) begin
                    errors++;
                    $display("FAIL to_data: got %h/%b/%b want %h/1/0", r0_rdata, arb_timeout,
                             r1_rdatavld, e.data);
                end
            end
            tick();
            if (cyc == 1) r0_read = 0;
        end
        checks++;
        if (pulses != 1 || got != 1) begin
            errors++;
            $display("FAIL to_pulse: got %0d pulses/%0d returns want 1/1", pulses, got);
            sb.delete();
        end
        sb.push_back('{req: 1'b1, addr: 17'h61, data: 32'h6161_6161});
        r1_addr = 17'h61; r1_wdata = 32'h6161_6161; r1_write = 1;
        for (int cyc = 0; cyc < 5 && found == 0; cyc++) begin
            @(negedge clk);
            if (m_write === 1'b1) begin
                e = sb.pop_front();
                found = 1;
                checks++;
                if ({m_addr, m_wdata} !== {e.addr, e.data}) begin
                    errors++;
                    $display("FAIL to_next_data: got %h/%h want %h/%h", m_addr, m_wdata, e.addr, e.data);
                end
            end
            tick();
        end
        r1_write = 0;
        checks++;
        if (found != 1) begin
            errors++;
            $display("FAIL to_next_grant: got %0d want 1", found);
            sb.delete();
        end
        tick();
    endtask
`else
    task automatic test_no_timeout();
        exp_t e;
        int   bad = 0;
        sb.push_back('{req: 1'b0, addr: 17'h60, data: 32'h0BAD_F00D});
        r0_addr = 17'h60; r0_read = 1; m_waitreq = 0;
        tick();
        tick();
        r0_read = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            if (arb_timeout !== 1'b0 || r0_rdatavld !== 1'b0) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL nto_wait: got %0d bad cycles want 0", bad);
        end
        m_rdatavld = 1; m_rdata = 32'h0BAD_F00D;
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        if ({r0_rdatavld, r0_rdata} !== {1'b1, e.data}) begin
            errors++;
            $display("FAIL nto_data: got %b/%h want 1/%h", r0_rdatavld, r0_rdata, e.data);
        end
        tick();
        m_rdatavld = 0;
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_single_write();
        test_round_robin();
        test_read();
        test_rw_both();
        test_reset_rdwait();
`ifdef SPIM_AVMM_ARB_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL sim_watchdog: got timeout want completion");
        $fatal(1, "simulation did not complete");
    end

endmodule

// File: doc/spim_avmm_arb.md
SPIM_AVMM_ARB -- requirements
Module: spim_avmm_arb

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 1023: CMD/RDWAIT watchdog limit in m_avmm_clk cycles, 10-bit range.
REQ-002 The block SHALL have port m_avmm_clk, input, 1 bit: the single clock.
REQ-003 The block SHALL have port m_avmm_rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have ports r0_avmm_addr/r1_avmm_addr, input, 17 bits each: requester address.
REQ-005 The block SHALL have ports r0_avmm_byte_en/r1_avmm_byte_en, input, 4 bits each: requester byte enables.
REQ-006 The block SHALL have ports r0_avmm_write/r1_avmm_write and r0_avmm_read/r1_avmm_read, input, 1 bit each: requester commands.
REQ-007 The block SHALL have ports r0_avmm_wdata/r1_avmm_wdata, input, 32 bits each: requester write data.
REQ-008 The block SHALL have ports r0_avmm_rdata/r1_avmm_rdata, output, 32 bits each: read data returned to the requester.
REQ-009 The block SHALL have ports r0_avmm_rdatavld/r1_avmm_rdatavld and r0_avmm_waitreq/r1_avmm_waitreq, output, 1 bit each: requester read-valid and wait-request.
REQ-010 The block SHALL have ports m_avmm_addr (17), m_avmm_byte_en (4), m_avmm_write (1), m_avmm_read (1) and m_avmm_wdata (32), all outputs: the SPI master AVMM command.
REQ-011 The block SHALL have ports m_avmm_rdata (32), m_avmm_rdatavld (1) and m_avmm_waitreq (1), all inputs: the SPI master AVMM response.
REQ-012 The block SHALL have port arb_timeout, output, 1 bit: single-cycle watchdog expiry pulse.

Function
REQ-013 The arbiter SHALL share one SPI master AVMM port between requesters r0 and r1 using FSM states IDLE, CMD and RDWAIT.
REQ-014 In IDLE, a requester SHALL count as requesting when its read or write is asserted; on any request, the FSM SHALL register the grant and enter CMD on the next cycle.
REQ-015 Grant selection SHALL be round-robin: when both request, the requester other than the last one completed wins; after reset, r0 wins the first tie.
REQ-016 In CMD, m_avmm_addr, byte_en, wdata, read and write SHALL be driven from the granted requester; all m_avmm_* outputs SHALL be zero outside CMD.
REQ-017 The granted requester's waitreq SHALL equal m_avmm_waitreq in CMD; waitreq SHALL be 1 in every other case, for both requesters, including the non-granted requester in every state.
REQ-018 When a requester asserts read and write together, the arbiter SHALL forward the write only, with m_avmm_read=0.
REQ-019 A write in CMD with m_avmm_waitreq=0 SHALL complete: the FSM returns to IDLE and the last-completed pointer updates.
REQ-020 A read in CMD with m_avmm_waitreq=0 SHALL move the FSM to RDWAIT.
REQ-021 In RDWAIT, on m_avmm_rdatavld=1 the arbiter SHALL present m_avmm_rdata with rdatavld=1 to the granted requester in the same cycle (combinational), then go to IDLE and update the pointer.
REQ-022 m_avmm_rdatavld outside RDWAIT SHALL be ignored, and rN_avmm_rdatavld SHALL stay 0.
REQ-023 If the granted requester drops both read and write in CMD, the FSM SHALL return to IDLE with no pointer update.
REQ-024 Minimum write occupancy SHALL be 2 cycles (IDLE→CMD→IDLE); back-to-back requests SHALL lose one IDLE cycle between grants.

Reset
REQ-025 While m_avmm_rst=1 at a clock edge, the FSM SHALL enter IDLE and the pointer SHALL be set so that r0 is preferred.
REQ-026 While m_avmm_rst=1, the watchdog counter SHALL clear, all m_avmm_* outputs SHALL be 0, both waitreq outputs SHALL be 1, and rdatavld and arb_timeout SHALL be 0.
REQ-027 A reset mid-CMD or mid-RDWAIT SHALL abandon the transaction; a later m_avmm_rdatavld SHALL be dropped.

Configuration
REQ-028 With macro SPIM_AVMM_ARB_TIMEOUT_EN defined, a 10-bit counter SHALL count cycles spent in CMD/RDWAIT, clearing on entry.
REQ-029 With SPIM_AVMM_ARB_TIMEOUT_EN defined, the counter reaching TIMEOUT_CYCLES SHALL pulse arb_timeout for 1 cycle and force IDLE with a pointer update.
REQ-030 With SPIM_AVMM_ARB_TIMEOUT_EN defined, a timeout in RDWAIT SHALL also return rdata=32'hDEAD_BEEF with rdatavld=1 to the granted requester in that cycle.
REQ-031 With SPIM_AVMM_ARB_TIMEOUT_EN undefined, no counter SHALL exist, arb_timeout SHALL be tied to 0, and the FSM SHALL wait indefinitely.

Verification
REQ-032 The bench SHALL cover: r0 write addr 17'h0_0010 wdata 32'h1234_5678, m_avmm_waitreq=0 → m_avmm_write=1 in cycle 2 only, with matching addr/data, r1_avmm_waitreq=1 throughout.
REQ-033 The bench SHALL cover: r0 and r1 both holding writes for 4 transactions → grant order r0,r1,r0,r1.
REQ-034 The bench SHALL cover: r1 read, m_avmm_waitreq low after 3 cycles, rdatavld with 32'hA5A5_0001 two cycles later → r1_avmm_rdata=32'hA5A5_0001, r1_avmm_rdatavld=1 for 1 cycle, r0 untouched.
REQ-035 The bench SHALL cover: reset asserted in RDWAIT, then a stray m_avmm_rdatavld → no rdatavld on either requester, FSM in IDLE.
REQ-036 The bench SHALL cover, with SPIM_AVMM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8: a read whose rdatavld never comes → arb_timeout pulses once, requester receives 32'hDEAD_BEEF, and the next request is granted.
